sd_spi_responder: RTL and testbench
===================================

Name: sd_spi_responder

Overview:
SPI mode-0 responder: the card-side end of the SD card link driven by the CPLD's byte-shifting SPI master. It oversamples SCLK, MOSI and nSCS on CLKX4, deserialises bytes and frames SD commands (6-byte CMDn packets). It then returns an R1 response byte on MISO after a programmable number of filler bytes. It is used as the SD card model in system benches and as a bridge to a host-side card emulator.

Parameters:
NCR, 1, number of 0xFF filler bytes sent between the last command byte and the R1 byte (legal range 1-8).
IDLE_BYTE, 8'hFF, byte shifted out whenever no response is pending.

Ports:
CLKX4  input  1  system clock; all logic is rising-edge clocked.
nRESET  input  1  asynchronous, active-low reset.
SCLK  input  1  SPI clock from the master; asynchronous to CLKX4.
MOSI  input  1  SPI data from the master.
nSCS  input  1  chip select, active low.
MISO  output  1  SPI data to the master.
MISO_oe  output  1  MISO drive enable; high only while synchronised nSCS is low.
RX_DATA  output  8  last complete byte received.
RX_STB  output  1  one-cycle pulse when RX_DATA updates.
CMD_VALID  output  1  one-cycle pulse when a 6-byte command frame completes.
CMD_INDEX  output  6  command index, bits [5:0] of frame byte 1.
CMD_ARG  output  32  argument, frame bytes 2-5, MSB first.
CMD_CRC_ERR  output  1  CRC status of the last frame; valid with CMD_VALID.
RESP_R1  input  8  R1 value, sampled at the moment the R1 byte is loaded for transmit.
BUSY  output  1  high from frame start until the R1 byte has fully shifted out.

Behaviour:
- Reset values: all outputs 0 except MISO=1. tx_shift=IDLE_BYTE, bit count 0, framer in IDLE.
- Synchronisers: SCLK, MOSI and nSCS each pass through 2 flops. Edges are detected from the synchronised SCLK and the previous sample. The master's minimum SCLK phase is 4 CLKX4 cycles, so every edge is detected.
- While synchronised nSCS is high:
  - SCLK edges are ignored; bit count is held at 0.
  - MISO_oe=0 and tx_shift reloads IDLE_BYTE.
  - The framer is forced to IDLE and any partial byte is discarded. No RX_STB or CMD_VALID is produced.
- SCLK rising edge: rx_shift <= {rx_shift[6:0], MOSI_sync}; bit count increments.
  - On the 8th rising edge: RX_DATA is set to the completed byte, RX_STB pulses 1 cycle later, the count wraps to 0, and the framer advances.
  - The next tx byte is loaded into tx_shift within 2 cycles of the 8th rising edge, so MISO is stable before the next byte's first rising edge.
- SCLK falling edge, excluding the one that follows the 8th rising edge: tx_shift <= {tx_shift[6:0], 1'b1}.
- MISO = tx_shift[7], MSB first.
- Framer (evaluated once per completed byte):
  - IDLE: byte[7:6]==2'b01 moves to CMD, stores the index, byte index=1, BUSY=1. Any other byte stays in IDLE.
  - CMD: collects bytes 2-6. After byte 6:
    - Latch CMD_ARG from bytes 2-5 and evaluate the CRC.
    - Pulse CMD_VALID, aligned with that byte's RX_STB.
    - Move to GAP with gap counter=NCR.
  - GAP: the next tx bytes are IDLE_BYTE. Each completed byte decrements the counter. The tx load after the byte that brings the counter to 0 selects R1 and moves to RESP.
  - RESP: tx_shift holds RESP_R1 (plus CRC override below). The byte that completes moves to IDLE and clears BUSY.
- Bytes received in GAP or RESP are reported on RX_STB but are not parsed as commands.
- Simultaneous events:
  - nSCS rising in the same cycle as the 8th rising edge: the deselect wins; the byte is dropped.
  - A reset mid-frame returns immediately to reset values.
- CMD_INDEX, CMD_ARG and CMD_CRC_ERR hold until the next CMD_VALID.

Optional Feature:
SD_CRC_CHECK_EN:
- Defined: CRC7 (polynomial x^7+x^3+1, initial 0) is computed over frame bytes 1-5 and compared to byte6[7:1].
  - On mismatch, or if byte6[0]!=1: CMD_CRC_ERR=1 and the transmitted R1 is RESP_R1|8'h08.
  - On match: CMD_CRC_ERR=0 and R1 is RESP_R1 unchanged.
- Undefined: no CRC logic; CMD_CRC_ERR is tied 0 and R1 is always RESP_R1.

Test Plan:
- nSCS=0, send 40 00 00 00 00 95, RESP_R1=01, NCR=1 -> CMD_VALID once, INDEX=0, ARG=0, CRC_ERR=0. MISO bytes on the following exchanges are FF then 01; BUSY clears after the 01.
- Send 48 00 00 01 AA 87 -> INDEX=8, ARG=32'h000001AA, CRC_ERR=0. With NCR=3, MISO returns FF FF FF then R1.
- With SD_CRC_CHECK_EN, send 40 00 00 00 00 00 and RESP_R1=01 -> CRC_ERR=1, R1 received=09. Without the macro -> CRC_ERR=0, R1=01.
- Send FF FF 3F before CMD0 -> three RX_STB with RX_DATA=FF, FF, 3F; no CMD_VALID; CMD0 then parses normally.
- Raise nSCS after 4 bits of byte 3 of a frame, lower it, then send a full CMD0 -> no RX_STB for the partial byte, framer restarts, exactly one CMD_VALID (INDEX=0).
- Assert nRESET mid-frame while SCLK is toggling with nSCS high -> all outputs at reset values, MISO=1, MISO_oe=0; the next CMD0 parses correctly.

Source files
------------

// File: rtl/sd_spi_responder.sv
// SD card SPI-mode-0 responder: oversamples the SPI pins on CLKX4, frames 6-byte commands, returns R1 after NCR filler bytes.
// Optional build macro SD_CRC_CHECK_EN enables CRC7 checking of each command frame.
module sd_spi_responder #(
    parameter int          NCR       = 1,
    parameter logic [7:0]  IDLE_BYTE = 8'hFF
) (
    input  logic        CLKX4,
    input  logic        nRESET,
    input  logic        SCLK,
    input  logic        MOSI,
    input  logic        nSCS,
    output logic        MISO,
    output logic        MISO_oe,
    output logic [7:0]  RX_DATA,
    output logic        RX_STB,
    output logic        CMD_VALID,
    output logic [5:0]  CMD_INDEX,
    output logic [31:0] CMD_ARG,
    output logic        CMD_CRC_ERR,
    input  logic [7:0]  RESP_R1,
    output logic        BUSY
);

    // state     | meaning
    // ST_IDLE   | waiting for a byte of the form 01xxxxxx
    // ST_CMD    | collecting frame bytes 2-6
    // ST_GAP    | sending NCR filler bytes
    // ST_RESP   | R1 byte loaded, waiting for it to shift out
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    logic [1:0]  sclk_sync;
    logic [1:0]  mosi_sync;
    logic [1:0]  nscs_sync;
    logic        sclk_prev;
    logic        selected;
    logic        sclk_rise;
    logic        sclk_fall;

    logic [6:0]  rx_shift;
    logic [2:0]  bit_cnt;
    logic        byte_pend;
    logic        skip_fall;

    logic [7:0]  tx_shift;
    logic [1:0]  state;
    logic [2:0]  byte_idx;
    logic [5:0]  cmd_idx_r;
    logic [31:0] arg_shift;
    logic [3:0]  gap_cnt;
    logic [7:0]  r1_val;

    always_ff @(posedge CLKX4 or negedge nRESET) begin
        if (!nRESET) begin
            sclk_sync <= 2'b00;
            mosi_sync <= 2'b00;
            nscs_sync <= 2'b11;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], SCLK};
            mosi_sync <= {mosi_sync[0], MOSI};
            nscs_sync <= {nscs_sync[0], nSCS};
            sclk_prev <= sclk_sync[1];
        end
    end

    assign selected  = ~nscs_sync[1];
    assign sclk_rise = sclk_sync[1] & ~sclk_prev;
    assign sclk_fall = ~sclk_sync[1] & sclk_prev;
    assign MISO      = tx_shift[7];
    assign MISO_oe   = selected;

    // Deserialiser; byte_pend marks the cycle the framer consumes RX_DATA.
    always_ff @(posedge CLKX4 or negedge nRESET) begin
        if (!nRESET) begin
            rx_shift  <= '0;
            bit_cnt   <= '0;
            RX_DATA   <= '0;
            byte_pend <= 1'b0;
            RX_STB    <= 1'b0;
            skip_fall <= 1'b0;
        end else if (!selected) begin
            rx_shift  <= '0;
            bit_cnt   <= '0;
            byte_pend <= 1'b0;
            RX_STB    <= 1'b0;
            skip_fall <= 1'b0;
        end else begin
            RX_STB    <= byte_pend;
            byte_pend <= 1'b0;
            if (sclk_rise) begin
                rx_shift <= {rx_shift[5:0], mosi_sync[1]};
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    RX_DATA   <= {rx_shift, mosi_sync[1]};
                    byte_pend <= 1'b1;
                    skip_fall <= 1'b1;
                end
            end else if (sclk_fall) begin
                skip_fall <= 1'b0;
            end
        end
    end

    // Framer and transmit path; the byte-boundary load replaces the skipped falling-edge shift.
    always_ff @(posedge CLKX4 or negedge nRESET) begin
        if (!nRESET) begin
            tx_shift  <= IDLE_BYTE;
            state     <= ST_IDLE;
            byte_idx  <= '0;
            cmd_idx_r <= '0;
            arg_shift <= '0;
            gap_cnt   <= '0;
            BUSY      <= 1'b0;
            CMD_VALID <= 1'b0;
            CMD_INDEX <= '0;
            CMD_ARG   <= '0;
        end else if (!selected) begin
            tx_shift  <= IDLE_BYTE;
            state     <= ST_IDLE;
            byte_idx  <= '0;
            gap_cnt   <= '0;
            BUSY      <= 1'b0;
            CMD_VALID <= 1'b0;
        end else begin
            CMD_VALID <= 1'b0;
            if (byte_pend) begin
                tx_shift <= IDLE_BYTE;
                case (state)
                    ST_IDLE: begin
                        if (RX_DATA[7:6] == 2'b01) begin
                            state     <= ST_CMD;
                            cmd_idx_r <= RX_DATA[5:0];
                            byte_idx  <= 3'd1;
                            BUSY      <= 1'b1;
                        end
                    end
                    ST_CMD: begin
                        if (byte_idx == 3'd5) begin
                            CMD_VALID <= 1'b1;
                            CMD_INDEX <= cmd_idx_r;
                            CMD_ARG   <= arg_shift;
                            gap_cnt   <= 4'(NCR);
                            state     <= ST_GAP;
                        end else begin
                            arg_shift <= {arg_shift[23:0], RX_DATA};
                            byte_idx  <= byte_idx + 3'd1;
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt == 4'd1) begin
                            tx_shift <= r1_val;
                            state    <= ST_RESP;
                        end
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                    default: begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                    end
                endcase
            end else if (sclk_fall && !skip_fall) begin
                tx_shift <= {tx_shift[6:0], 1'b1};
            end
        end
    end

`ifdef SD_CRC_CHECK_EN
    logic [6:0] crc_acc;
    logic       crc_fail;

    function automatic logic [6:0] crc7_byte(input logic [6:0] crc_in, input logic [7:0] data);
        logic [6:0] c;
        logic       fb;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[6] ^ data[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    assign crc_fail = (crc_acc != RX_DATA[7:1]) | ~RX_DATA[0];
    assign r1_val   = RESP_R1 | (CMD_CRC_ERR ? 8'h08 : 8'h00);

    always_ff @(posedge CLKX4 or negedge nRESET) begin
        if (!nRESET) begin
            crc_acc     <= '0;
            CMD_CRC_ERR <= 1'b0;
        end else if (selected && byte_pend) begin
            if (state == ST_IDLE && RX_DATA[7:6] == 2'b01) begin
                crc_acc <= crc7_byte(7'd0, RX_DATA);
            end else if (state == ST_CMD) begin
                if (byte_idx == 3'd5) CMD_CRC_ERR <= crc_fail;
                else                  crc_acc     <= crc7_byte(crc_acc, RX_DATA);
            end
        end
    end
`else
    assign CMD_CRC_ERR = 1'b0;
    assign r1_val      = RESP_R1;
`endif

endmodule

// File: tb/tb_sd_spi_responder.sv
// Directed bench for sd_spi_responder: one NCR=1 instance checked in full, one NCR=3 instance for filler-length checks.
module tb_sd_spi_responder;

    logic        CLKX4   = 1'b0;
    logic        nRESET  = 1'b0;
    logic        SCLK    = 1'b0;
    logic        MOSI    = 1'b0;
    logic        nSCS    = 1'b1;
    logic [7:0]  RESP_R1 = 8'h01;

    logic        miso, miso_oe, rx_stb, cmd_valid, cmd_crc_err, busy;
    logic [7:0]  rx_data;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;

    logic        miso3, miso_oe3, rx_stb3, cmd_valid3, cmd_crc_err3, busy3;
    logic [7:0]  rx_data3;
    logic [5:0]  cmd_index3;
    logic [31:0] cmd_arg3;

    sd_spi_responder #(.NCR(1), .IDLE_BYTE(8'hFF)) dut (
        .CLKX4(CLKX4), .nRESET(nRESET), .SCLK(SCLK), .MOSI(MOSI), .nSCS(nSCS),
        .MISO(miso), .MISO_oe(miso_oe), .RX_DATA(rx_data), .RX_STB(rx_stb),
        .CMD_VALID(cmd_valid), .CMD_INDEX(cmd_index), .CMD_ARG(cmd_arg),
        .CMD_CRC_ERR(cmd_crc_err), .RESP_R1(RESP_R1), .BUSY(busy)
    );

    sd_spi_responder #(.NCR(3), .IDLE_BYTE(8'hFF)) dut3 (
        .CLKX4(CLKX4), .nRESET(nRESET), .SCLK(SCLK), .MOSI(MOSI), .nSCS(nSCS),
        .MISO(miso3), .MISO_oe(miso_oe3), .RX_DATA(rx_data3), .RX_STB(rx_stb3),
        .CMD_VALID(cmd_valid3), .CMD_INDEX(cmd_index3), .CMD_ARG(cmd_arg3),
        .CMD_CRC_ERR(cmd_crc_err3), .RESP_R1(RESP_R1), .BUSY(busy3)
    );

    always #5 CLKX4 = ~CLKX4;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    logic [7:0] rx_q[$];
    int         cmd_cnt  = 0;
    int         misalign = 0;

    always @(negedge CLKX4) begin
        if (rx_stb) rx_q.push_back(rx_data);
        if (cmd_valid) begin
            cmd_cnt++;
            if (!rx_stb) misalign++;
        end
    end

    // Mode-0 master: MOSI set while SCLK low, MISO sampled just before the rising edge.
    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx, output logic [7:0] rx3);
        for (int i = 7; i >= 0; i--) begin
            MOSI = tx[i];
            #50;
            rx[i]  = miso;
            rx3[i] = miso3;
            SCLK = 1'b1;
            #50;
            SCLK = 1'b0;
        end
        #100;
    endtask

    task automatic xfer_partial(input logic [7:0] tx, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            MOSI = tx[i];
            #50;
            SCLK = 1'b1;
            #50;
            SCLK = 1'b0;
        end
        #50;
    endtask

    task automatic send_frame(input string tag, input logic [47:0] frame);
        logic [7:0] r, r3;
        for (int k = 0; k < 6; k++) begin
            xfer(frame[47-8*k -: 8], r, r3);
            check_val({tag, "_miso_idle"}, r, 8'hFF);
        end
    endtask

    task automatic select_card();
        nSCS = 1'b0;
        #100;
    endtask

    task automatic deselect_card();
        nSCS = 1'b1;
        #100;
    endtask

    logic [7:0] r, r3;
    int         c0;

    initial begin
        #32;
        check_val("rst_miso", miso, 1'b1);
        check_val("rst_miso_oe", miso_oe, 1'b0);
        check_val("rst_busy", busy, 1'b0);
        nRESET = 1'b1;
        #20;
        check_val("rst_rx_data", rx_data, 8'h00);
        check_val("rst_rx_stb", rx_stb, 1'b0);
        check_val("rst_cmd_valid", cmd_valid, 1'b0);
        check_val("rst_cmd_index", cmd_index, 6'd0);
        check_val("rst_cmd_arg", cmd_arg, 32'h0);
        check_val("rst_crc_err", cmd_crc_err, 1'b0);

        // CMD0 with good CRC, NCR=1
        select_card();
        check_val("cmd0_miso_oe", miso_oe, 1'b1);
        send_frame("cmd0", 48'h40_00000000_95);
        check_val("cmd0_count", cmd_cnt, 1);
        check_val("cmd0_align", misalign, 0);
        check_val("cmd0_index", cmd_index, 6'd0);
        check_val("cmd0_arg", cmd_arg, 32'h0);
        check_val("cmd0_crc_err", cmd_crc_err, 1'b0);
        check_val("cmd0_rx_count", rx_q.size(), 6);
        check_val("cmd0_busy_gap", busy, 1'b1);
        xfer(8'hFF, r, r3);
        check_val("cmd0_fill", r, 8'hFF);
        check_val("cmd0_busy_resp", busy, 1'b1);
        xfer(8'hFF, r, r3);
        check_val("cmd0_r1", r, 8'h01);
        check_val("cmd0_busy_done", busy, 1'b0);
        deselect_card();

        // CMD0 with zero CRC byte
        select_card();
        c0 = cmd_cnt;
        send_frame("badcrc", 48'h40_00000000_00);
        check_val("badcrc_count", cmd_cnt, c0 + 1);
        xfer(8'hFF, r, r3);
        check_val("badcrc_fill", r, 8'hFF);
        xfer(8'hFF, r, r3);
`ifdef SD_CRC_CHECK_EN
        check_val("badcrc_err", cmd_crc_err, 1'b1);
        check_val("badcrc_r1", r, 8'h09);
`else
        check_val("badcrc_err", cmd_crc_err, 1'b0);
        check_val("badcrc_r1", r, 8'h01);
`endif
        deselect_card();

        // Non-command bytes ahead of CMD0
        select_card();
        rx_q.delete();
        c0 = cmd_cnt;
        xfer(8'hFF, r, r3);
        xfer(8'hFF, r, r3);
        xfer(8'h3F, r, r3);
        check_val("junk_rx_count", rx_q.size(), 3);
        check_val("junk_rx0", rx_q[0], 8'hFF);
        check_val("junk_rx1", rx_q[1], 8'hFF);
        check_val("junk_rx2", rx_q[2], 8'h3F);
        check_val("junk_no_cmd", cmd_cnt, c0);
        send_frame("junk_cmd0", 48'h40_00000000_95);
        check_val("junk_cmd0_count", cmd_cnt, c0 + 1);
        check_val("junk_cmd0_arg", cmd_arg, 32'h0);
        check_val("junk_cmd0_crc_err", cmd_crc_err, 1'b0);
        xfer(8'hFF, r, r3);
        xfer(8'hFF, r, r3);
        check_val("junk_cmd0_r1", r, 8'h01);
        deselect_card();

        // Deselect part-way through byte 3
        select_card();
        rx_q.delete();
        c0 = cmd_cnt;
        xfer(8'h40, r, r3);
        xfer(8'h00, r, r3);
        xfer_partial(8'h00, 4);
        deselect_card();
        select_card();
        send_frame("abort", 48'h40_00000000_95);
        check_val("abort_rx_count", rx_q.size(), 8);
        check_val("abort_rx2", rx_q[2], 8'h40);
        check_val("abort_rx7", rx_q[7], 8'h95);
        check_val("abort_count", cmd_cnt, c0 + 1);
        check_val("abort_index", cmd_index, 6'd0);
        check_val("abort_arg", cmd_arg, 32'h0);
        xfer(8'hFF, r, r3);
        xfer(8'hFF, r, r3);
        check_val("abort_r1", r, 8'h01);
        deselect_card();

        // CMD8; NCR=1 and NCR=3 instances side by side
        select_card();
        send_frame("cmd8", 48'h48_000001AA_87);
        check_val("cmd8_index", cmd_index, 6'd8);
        check_val("cmd8_arg", cmd_arg, 32'h000001AA);
        check_val("cmd8_crc_err", cmd_crc_err, 1'b0);
        check_val("cmd8_n3_index", cmd_index3, 6'd8);
        check_val("cmd8_n3_arg", cmd_arg3, 32'h000001AA);
        check_val("cmd8_n3_crc_err", cmd_crc_err3, 1'b0);
        check_val("cmd8_n3_rx_data", rx_data3, 8'h87);
        check_val("cmd8_n3_stb_idle", {rx_stb3, cmd_valid3}, 2'b00);
        check_val("cmd8_n3_miso_oe", miso_oe3, 1'b1);
        xfer(8'hFF, r, r3);
        check_val("cmd8_fill1", r, 8'hFF);
        check_val("cmd8_n3_fill1", r3, 8'hFF);
        xfer(8'hFF, r, r3);
        check_val("cmd8_r1", r, 8'h01);
        check_val("cmd8_n3_fill2", r3, 8'hFF);
        xfer(8'hFF, r, r3);
        check_val("cmd8_n3_fill3", r3, 8'hFF);
        check_val("cmd8_n3_busy", busy3, 1'b1);
        xfer(8'hFF, r, r3);
        check_val("cmd8_n3_r1", r3, 8'h01);
        check_val("cmd8_n3_busy_done", busy3, 1'b0);

        // Reset mid-frame while SCLK toggles deselected
        xfer(8'h40, r, r3);
        xfer(8'h00, r, r3);
        check_val("rst2_busy_before", busy, 1'b1);
        nSCS = 1'b1;
        for (int i = 0; i < 4; i++) begin
            SCLK = 1'b1;
            #50;
            SCLK = 1'b0;
            if (i == 1) nRESET = 1'b0;
            #50;
        end
        check_val("rst2_miso", miso, 1'b1);
        check_val("rst2_miso_oe", miso_oe, 1'b0);
        check_val("rst2_rx_data", rx_data, 8'h00);
        check_val("rst2_strobes", {rx_stb, cmd_valid}, 2'b00);
        check_val("rst2_cmd_index", cmd_index, 6'd0);
        check_val("rst2_cmd_arg", cmd_arg, 32'h0);
        check_val("rst2_busy", busy, 1'b0);
        nRESET = 1'b1;
        #100;
        c0 = cmd_cnt;
        select_card();
        send_frame("rst2_cmd0", 48'h40_00000000_95);
        check_val("rst2_cmd0_count", cmd_cnt, c0 + 1);
        check_val("rst2_cmd0_index", cmd_index, 6'd0);
        xfer(8'hFF, r, r3);
        xfer(8'hFF, r, r3);
        check_val("rst2_cmd0_r1", r, 8'h01);
        check_val("final_align", misalign, 0);
        deselect_card();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
